// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage plus the IF/ID pipeline register. It holds the PC,
// runs a request/ready handshake with instruction memory and hands the fetched
// word and its PC+4 to decode. Branch and jump redirects resolved further down
// the pipe flush IF/ID and retarget the PC. A decode hazard stall freezes
// IF/ID, and a word that arrives during a stall is parked in a one-entry
// buffer.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   stall           : decode hazard, hold IF/ID and PC
//   br_taken, jump  : redirect pulses (jump wins when both are high)
//   rd_pc4          : PC+4 of the redirecting instruction
//   br_imm          : signed branch offset in words
//   j_index         : jump target index
//   imem_req/addr   : fetch request and word address
//   imem_ready/rdata: response valid strobe and instruction word
//   ifid_instr      : instruction to decode (32'h0 when not valid)
//   ifid_pc4        : PC+4 of ifid_instr
//   ifid_valid      : IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic        jump,
   input  logic [31:0] rd_pc4,
   input  logic [15:0] br_imm,
   input  logic [25:0] j_index,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid
);

   // FETCH : request outstanding at pc
   // HOLD  : a fetched word sits in the buffer, no request
   // KILL  : request outstanding at kill_addr, its response is thrown away
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      KILL  = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] kill_addr;   // address of the request being discarded
   logic [31:0] buf_instr;
   logic [31:0] buf_pc4;

   logic        redirect;
   logic        handshake;
   logic [31:0] pc_plus4;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] target;

   // NOTE: every signal assigned in always_comb is given a value on every
   // path, otherwise synthesis infers a latch to remember the old value.
   always_comb begin
      br_target = rd_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
      j_target  = {rd_pc4[31:28], j_index, 2'b00};
      target    = jump ? j_target : br_target;
      redirect  = br_taken | jump;
      pc_plus4  = pc + 32'd4;
   end

   // The request is gated with rst so that memory never sees a request while
   // reset is held; it reappears in the first cycle after release.
   assign imem_req  = ~rst & (state != HOLD);
   // In KILL the PC already holds the redirect target, but the address of the
   // outstanding request must not move until its response arrives.
   assign imem_addr = (state == KILL) ? kill_addr : pc;
   assign handshake = imem_req & imem_ready;

   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         kill_addr  <= 32'h0;
         buf_instr  <= 32'h0;
         buf_pc4    <= 32'h0;
         ifid_instr <= 32'h0;
         ifid_pc4   <= 32'h0;
         ifid_valid <= 1'b0;
      end else if (redirect) begin
         // A redirect flushes IF/ID and overrides stall in every state.
         ifid_instr <= 32'h0;
         ifid_valid <= 1'b0;
         pc         <= target;
         unique case (state)
            FETCH: begin
               if (!handshake) begin
                  // Request still in flight: park its address and drop the
                  // response when it comes back.
                  kill_addr <= pc;
                  state     <= KILL;
               end
            end
            HOLD:    state <= FETCH;
            KILL:    if (handshake) state <= FETCH;
            default: state <= FETCH;
         endcase
      end else begin
         unique case (state)
            FETCH: begin
               if (handshake) begin
                  pc <= pc_plus4;
                  if (stall) begin
                     buf_instr <= imem_rdata;
                     buf_pc4   <= pc_plus4;
                     state     <= HOLD;
                  end else begin
                     ifid_instr <= imem_rdata;
                     ifid_pc4   <= pc_plus4;
                     ifid_valid <= 1'b1;
                  end
               end else if (!stall) begin
                  // Nothing arrived and decode consumed IF/ID: insert a bubble.
                  ifid_instr <= 32'h0;
                  ifid_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  ifid_instr <= buf_instr;
                  ifid_pc4   <= buf_pc4;
                  ifid_valid <= 1'b1;
                  state      <= FETCH;
               end
            end
            KILL: begin
               if (handshake) state <= FETCH;
               if (!stall) begin
                  ifid_instr <= 32'h0;
                  ifid_valid <= 1'b0;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed sequence covering reset, streaming, wait states, stall/HOLD,
// branch, jump-while-pending, simultaneous redirect with stall and reset in
// the middle of a killed request; followed by a randomized phase checked
// against an instruction-stream model: every delivered word must be the next
// sequential word of the current program path, redirects restart the path at
// the computed target, stalls freeze IF/ID, and a waiting request must keep
// its address.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        br_taken;
   logic        jump;
   logic [31:0] rd_pc4;
   logic [15:0] br_imm;
   logic [25:0] j_index;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;

   // Memory model: word at address a is a ^ mem_key; garbage when not ready.
   logic [31:0] mem_key;
   assign imem_rdata = imem_ready ? (imem_addr ^ mem_key) : 32'hDEAD_BEEF;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .br_taken   (br_taken),
      .jump       (jump),
      .rd_pc4     (rd_pc4),
      .br_imm     (br_imm),
      .j_index    (j_index),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .ifid_instr (ifid_instr),
      .ifid_pc4   (ifid_pc4),
      .ifid_valid (ifid_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid);
      check({tag, ".instr"}, ifid_instr, instr);
      check({tag, ".pc4"},   ifid_pc4,   pc4);
      check({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, valid});
   endtask

   task automatic check_flushed(input string tag);
      check({tag, ".instr"}, ifid_instr, 32'h0);
      check({tag, ".valid"}, {31'b0, ifid_valid}, 32'h0);
   endtask

   // Advance one cycle and sample 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1);
   end

   // Random-phase model state
   logic [31:0] exp_pc;
   logic        prev_pending;
   logic [31:0] prev_addr;
   logic        m_redir;
   logic        m_stall;
   logic [31:0] m_target;
   logic [31:0] m_off;
   logic [31:0] held_instr;
   logic [31:0] held_pc4;
   logic        held_valid;
   int          delivered;

   initial begin
      rst        = 1'b1;
      stall      = 1'b0;
      br_taken   = 1'b0;
      jump       = 1'b0;
      rd_pc4     = 32'h0;
      br_imm     = 16'h0;
      j_index    = 26'h0;
      imem_ready = 1'b1;
      mem_key    = 32'h0;

      // ---- reset state ----
      #3;
      check("rst.req", {31'b0, imem_req}, 32'h0);
      check("rst.addr", imem_addr, 32'h0);
      check_ifid("rst", 32'h0, 32'h0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rel.req", {31'b0, imem_req}, 32'h1);
      check("rel.addr", imem_addr, 32'h0);

      // ---- streaming with ready tied high: one word per cycle ----
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stream.addr", imem_addr, 32'(4 * i + 4));
         check_ifid("stream", 32'(4 * i), 32'(4 * i + 4), 1'b1);
      end

      // ---- ready every third cycle: address stable, valid 0,0,1 ----
      for (int k = 0; k < 3; k++) begin
         imem_ready = (k == 2);
         tick();
         if (k < 2) begin
            check("wait.addr", imem_addr, 32'h0C);
            check_flushed("wait");
         end else begin
            check("wait.addr_next", imem_addr, 32'h10);
            check_ifid("wait.word", 32'h0C, 32'h10, 1'b1);
         end
      end

      // ---- stall while word at 0x10 returns -> HOLD ----
      imem_ready = 1'b1;
      stall      = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("hold.req", {31'b0, imem_req}, 32'h0);
         check("hold.addr", imem_addr, 32'h14);
         check_ifid("hold", 32'h0C, 32'h10, 1'b1);
      end
      stall = 1'b0;
      tick();
      check_ifid("unhold", 32'h10, 32'h14, 1'b1);
      check("unhold.req", {31'b0, imem_req}, 32'h1);
      check("unhold.addr", imem_addr, 32'h14);
      tick();
      check_ifid("after_hold", 32'h14, 32'h18, 1'b1);
      check("after_hold.addr", imem_addr, 32'h18);

      // ---- taken branch with negative offset ----
      br_taken = 1'b1;
      rd_pc4   = 32'h20;
      br_imm   = 16'hFFFC;
      tick();
      br_taken = 1'b0;
      check_flushed("br.flush");
      check("br.addr", imem_addr, 32'h10);
      tick();
      check_ifid("br.target", 32'h10, 32'h14, 1'b1);
      check("br.addr_next", imem_addr, 32'h14);

      // ---- move PC to 0x40, then jump while that request is pending ----
      br_taken = 1'b1;
      rd_pc4   = 32'h40;
      br_imm   = 16'h0;
      tick();
      br_taken = 1'b0;
      check("pre_jump.addr", imem_addr, 32'h40);
      imem_ready = 1'b0;
      jump       = 1'b1;
      j_index    = 26'h10;
      rd_pc4     = 32'h8000_0004;
      tick();
      jump = 1'b0;
      check("kill.addr", imem_addr, 32'h40);
      check("kill.req", {31'b0, imem_req}, 32'h1);
      check_flushed("kill.flush");
      tick();
      check("kill.addr_wait", imem_addr, 32'h40);
      check_flushed("kill.wait");
      imem_ready = 1'b1;
      tick();
      check("kill.done_addr", imem_addr, 32'h8000_0040);
      check_flushed("kill.discard");
      tick();
      check_ifid("jump.target", 32'h8000_0040, 32'h8000_0044, 1'b1);
      check("jump.addr_next", imem_addr, 32'h8000_0044);

      // ---- branch and jump together under stall: jump wins, flush wins ----
      br_taken = 1'b1;
      jump     = 1'b1;
      stall    = 1'b1;
      rd_pc4   = 32'h0000_1000;
      br_imm   = 16'h0004;
      j_index  = 26'h100;
      tick();
      br_taken = 1'b0;
      jump     = 1'b0;
      check("both.addr", imem_addr, 32'h400);
      check("both.req", {31'b0, imem_req}, 32'h1);
      check_flushed("both.flush");
      tick();
      check("both.hold_req", {31'b0, imem_req}, 32'h0);
      check_flushed("both.hold");
      stall = 1'b0;
      tick();
      check_ifid("both.target", 32'h400, 32'h404, 1'b1);
      check("both.addr_next", imem_addr, 32'h404);

      // ---- enter KILL, then reset asynchronously in the middle of it ----
      imem_ready = 1'b0;
      jump       = 1'b1;
      j_index    = 26'h200;
      rd_pc4     = 32'h0;
      tick();
      jump = 1'b0;
      check("rk.addr", imem_addr, 32'h404);
      check_flushed("rk.flush");
      rst = 1'b1;
      #2;
      check("rk.rst_req", {31'b0, imem_req}, 32'h0);
      check("rk.rst_addr", imem_addr, 32'h0);
      check_ifid("rk.rst", 32'h0, 32'h0, 1'b0);
      #1;
      rst        = 1'b0;
      imem_ready = 1'b1;
      tick();
      check_ifid("rk.restart", 32'h0, 32'h4, 1'b1);
      check("rk.restart_addr", imem_addr, 32'h4);

      // ---- randomized phase against the instruction-stream model ----
      mem_key = 32'h1357_9BDF;
      rst     = 1'b1;
      #2;
      rst          = 1'b0;
      exp_pc       = 32'h0;
      prev_pending = 1'b0;
      prev_addr    = 32'h0;
      delivered    = 0;
      for (int c = 0; c < 3000; c++) begin
         int r;
         r          = int'($urandom_range(0, 19));
         imem_ready = ($urandom_range(0, 9) < 6);
         stall      = ($urandom_range(0, 3) == 0);
         br_taken   = (r == 0) || (r == 2);
         jump       = (r == 1) || (r == 2);
         rd_pc4     = $urandom & 32'hFFFF_FFFC;
         br_imm     = 16'($urandom);
         j_index    = 26'($urandom);
         #1;
         if (prev_pending) begin
            check("rand.addr_stable", imem_addr, prev_addr);
            check("rand.req_stable", {31'b0, imem_req}, 32'h1);
         end
         check("rand.align", {30'b0, imem_addr[1:0]}, 32'h0);
         prev_pending = imem_req & ~imem_ready;
         prev_addr    = imem_addr;
         m_redir      = br_taken | jump;
         m_stall      = stall;
         m_off        = {{16{br_imm[15]}}, br_imm};
         m_target     = jump ? {rd_pc4[31:28], j_index, 2'b00} : rd_pc4 + m_off * 32'd4;
         held_instr   = ifid_instr;
         held_pc4     = ifid_pc4;
         held_valid   = ifid_valid;
         tick();
         if (m_redir) begin
            check_flushed("rand.redirect");
            exp_pc = m_target;
         end else if (m_stall) begin
            check_ifid("rand.stall_hold", held_instr, held_pc4, held_valid);
         end else if (ifid_valid) begin
            check("rand.instr", ifid_instr, exp_pc ^ mem_key);
            check("rand.pc4", ifid_pc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end else begin
            check("rand.bubble_instr", ifid_instr, 32'h0);
         end
      end
      check("rand.progress", {31'b0, delivered > 200}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
